piso_stream_out: RTL and testbench
==================================

// Module: piso_stream_out
// PURPOSE
// - Parametrised successor to the output PISO stage of the NPU result path.
// - Captures NUM_TAPS words of WIDTH bits in parallel from the accumulator/argmax stage.
// - Serialises a per-load count of those words onto a valid/ready output stream, with
//   selectable order and a last-beat flag.
// - Sits between the NPU core result bus and the external/host readout interface.
// PARAMETERS
// - WIDTH     8  bits per word
// - NUM_TAPS  4  words per parallel load (>=2)
// - CW        $clog2(NUM_TAPS+1)  width of count fields (localparam)
// PORTS
// - CLKEXT     in   1               single clock, rising edge
// - CLR_N      in   1               asynchronous active-low reset
// - FLUSH      in   1               synchronous abort: discard all held data
// - IN_VALID   in   1               parallel word set offered
// - IN_READY   out  1               block accepts the parallel set this cycle
// - DATA_IN    in   WIDTH*NUM_TAPS  tap i = DATA_IN[WIDTH*i +: WIDTH]
// - LOAD_CNT   in   CW              taps to emit, 1..NUM_TAPS; 0 or >NUM_TAPS -> NUM_TAPS
// - DIR        in   1               0: tap CNT-1 first, down to tap 0; 1: tap 0 first, up to CNT-1
// - OUT_VALID  out  1               DATA_OUT holds a valid beat
// - OUT_READY  in   1               downstream accepts the beat
// - DATA_OUT   out  WIDTH           current beat
// - OUT_LAST   out  1               current beat is the final one of this load
// - BUSY       out  1               a load is held or being emitted
// BEHAVIOUR
// - Reset (CLR_N=0, async):
//   - All storage cleared; FSM in IDLE.
//   - IN_READY=0, OUT_VALID=0, OUT_LAST=0, DATA_OUT=0, BUSY=0.
// - FSM: IDLE -> SHIFT on accepted load. SHIFT -> IDLE on the last accepted beat.
//   With skid enabled and the skid full, SHIFT stays in SHIFT instead.
// - Load: occurs when IN_VALID & IN_READY at an edge.
//   - DATA_IN, the clamped LOAD_CNT and DIR are captured.
//   - DIR is sampled only at load; later changes are ignored until the next load.
// - Latency: load at edge k -> OUT_VALID=1 with the first beat after edge k.
//   The first beat is tap CNT-1 (DIR=0) or tap 0 (DIR=1).
// - Beat transfer: occurs when OUT_VALID & OUT_READY at an edge.
//   - The pointer steps by one tap (-1 for DIR=0, +1 for DIR=1).
//   - The remaining count decrements.
//   - While OUT_READY=0: DATA_OUT, OUT_LAST and OUT_VALID hold stable (AXI-style). OUT_VALID never drops without a transfer.
// - OUT_LAST=1 exactly when remaining==1. CNT=1 gives a single beat with OUT_LAST=1.
// - Pointer never wraps: it only ever covers taps 0..CNT-1. Taps >=CNT are never emitted.
// - FLUSH=1 at an edge:
//   - FSM -> IDLE; holding and skid registers are invalidated.
//   - OUT_VALID=0 the next cycle; any concurrent load or beat is dropped.
//   - IN_READY=0 while FLUSH=1.
// - Priority: CLR_N > FLUSH > transfer/load.
// - BUSY = (FSM==SHIFT) | skid_full.
// - All outputs are registered or decoded from registered state. There is no
//   combinational IN_VALID->OUT_VALID path and no OUT_READY->OUT_VALID path.
// CONFIGURATION
// - Macro PISO_STREAM_SKID_EN selects whether a one-entry skid buffer is built.
// - Macro not defined (no skid):
//   - IN_READY = (FSM==IDLE) & CLR_N & ~FLUSH.
//   - The next load is accepted only in IDLE.
//   - Result: a 1-cycle OUT_VALID gap between back-to-back loads.
// - Macro defined (skid buffer):
//   - Adds a one-entry skid buffer holding DATA_IN, CNT and DIR.
//   - IN_READY = ~skid_full & CLR_N & ~FLUSH. A load during SHIFT goes into the skid.
//   - On the last-beat transfer the skid contents move straight into the shift register.
//     OUT_VALID stays 1 and the next cycle presents that load's first beat (zero bubble).
//   - A load arriving in IDLE bypasses the skid.
//   - A load arriving on the same edge as the last beat while the skid is empty
//     goes directly to the shift register.
// TESTING (WIDTH=8, NUM_TAPS=4, DATA_IN=32'h44332211)
// - T1 reset/idle:
//   - Stimulus: hold CLR_N=0 mid-SHIFT, then release.
//   - Required: all outputs 0 while CLR_N=0; IN_READY=1 on the first cycle after release.
// - T2 order:
//   - Stimulus: LOAD_CNT=4, DIR=0, OUT_READY=1.
//   - Required: beats 44,33,22,11 on 4 consecutive cycles; OUT_LAST only with 11.
//   - Repeat with DIR=1. Required: 11,22,33,44.
// - T3 count clamp:
//   - LOAD_CNT=2, DIR=0 -> required: 22,11.
//   - LOAD_CNT=1 -> required: single beat 11 with OUT_LAST=1.
//   - LOAD_CNT=0 -> required: 4 beats.
// - T4 backpressure:
//   - Stimulus: OUT_READY toggles 1,0,0,1,1,0,1.
//   - Required: DATA_OUT stable across stalls; exactly 4 transfers, in order 44,33,22,11.
// - T5 flush:
//   - Stimulus: FLUSH=1 after the beat 33 is accepted.
//   - Required: OUT_VALID=0 the next cycle; beats 22 and 11 are never seen; the next load starts clean.
// - T6 back-to-back:
//   - Stimulus: load A=32'h44332211, then B=32'h88776655 offered immediately, DIR=0, OUT_READY=1.
//   - Required with skid: 8 contiguous beats 44..11,88..55.
//   - Required without skid: one OUT_VALID=0 cycle between 11 and 88.

Source files
------------

// File: rtl/piso_stream_out.sv
// piso_stream_out: parallel-load, serial valid/ready output stage with selectable order and last flag.
// Optional one-entry skid buffer for zero-bubble back-to-back loads: define PISO_STREAM_SKID_EN.
`default_nettype none

module piso_stream_out #(
    parameter int  WIDTH    = 8,
    parameter int  NUM_TAPS = 4,
    localparam int CW       = $clog2(NUM_TAPS + 1)
) (
    input  logic                      CLKEXT,
    input  logic                      CLR_N,
    input  logic                      FLUSH,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [WIDTH*NUM_TAPS-1:0] DATA_IN,
    input  logic [CW-1:0]             LOAD_CNT,
    input  logic                      DIR,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [WIDTH-1:0]          DATA_OUT,
    output logic                      OUT_LAST,
    output logic                      BUSY
);

    localparam int PW = $clog2(NUM_TAPS);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [WIDTH*NUM_TAPS-1:0] data_q, data_d;
    logic [CW-1:0]             rem_q, rem_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic                      dir_q, dir_d;
    logic [CW-1:0]             in_cnt;
    logic                      load, xfer, last_xfer;

`ifdef PISO_STREAM_SKID_EN
    logic                      skid_full_q, skid_full_d;
    logic [WIDTH*NUM_TAPS-1:0] skid_data_q, skid_data_d;
    logic [CW-1:0]             skid_cnt_q, skid_cnt_d;
    logic                      skid_dir_q, skid_dir_d;
`endif

    // Out-of-range counts fall back to a full-width emission.
    assign in_cnt = ((LOAD_CNT == '0) || (LOAD_CNT > CW'(NUM_TAPS))) ? CW'(NUM_TAPS) : LOAD_CNT;

    function automatic logic [PW-1:0] first_ptr(input logic [CW-1:0] cnt, input logic dir);
        return dir ? '0 : PW'(cnt - CW'(1));
    endfunction

`ifdef PISO_STREAM_SKID_EN
    assign IN_READY = ~skid_full_q & CLR_N & ~FLUSH;
    assign BUSY     = (state_q == S_SHIFT) | skid_full_q;
`else
    assign IN_READY = (state_q == S_IDLE) & CLR_N & ~FLUSH;
    assign BUSY     = (state_q == S_SHIFT);
`endif

    assign OUT_VALID = (state_q == S_SHIFT);
    assign OUT_LAST  = OUT_VALID & (rem_q == CW'(1));
    assign load      = IN_VALID & IN_READY;
    assign xfer      = OUT_VALID & OUT_READY;
    assign last_xfer = xfer & (rem_q == CW'(1));

    always_comb begin
        DATA_OUT = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (OUT_VALID && (ptr_q == PW'(i))) begin
                DATA_OUT = data_q[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
`ifdef PISO_STREAM_SKID_EN
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_cnt_d  = skid_cnt_q;
        skid_dir_d  = skid_dir_q;
`endif
        if (FLUSH) begin
            state_d = S_IDLE;
`ifdef PISO_STREAM_SKID_EN
            skid_full_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        state_d = S_SHIFT;
                        data_d  = DATA_IN;
                        rem_d   = in_cnt;
                        dir_d   = DIR;
                        ptr_d   = first_ptr(in_cnt, DIR);
                    end
                end
                default: begin
                    if (last_xfer) begin
`ifdef PISO_STREAM_SKID_EN
                        if (skid_full_q) begin
                            data_d      = skid_data_q;
                            rem_d       = skid_cnt_q;
                            dir_d       = skid_dir_q;
                            ptr_d       = first_ptr(skid_cnt_q, skid_dir_q);
                            skid_full_d = 1'b0;
                        end else if (load) begin
                            data_d = DATA_IN;
                            rem_d  = in_cnt;
                            dir_d  = DIR;
                            ptr_d  = first_ptr(in_cnt, DIR);
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end else if (xfer) begin
                        rem_d = rem_q - CW'(1);
                        ptr_d = dir_q ? ptr_q + PW'(1) : ptr_q - PW'(1);
                    end
`ifdef PISO_STREAM_SKID_EN
                    // Loads arriving mid-emission park in the skid until the last beat leaves.
                    if (load && !last_xfer) begin
                        skid_full_d = 1'b1;
                        skid_data_d = DATA_IN;
                        skid_cnt_d  = in_cnt;
                        skid_dir_d  = DIR;
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge CLKEXT or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            dir_q   <= 1'b0;
`ifdef PISO_STREAM_SKID_EN
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_cnt_q  <= '0;
            skid_dir_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
`ifdef PISO_STREAM_SKID_EN
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_cnt_q  <= skid_cnt_d;
            skid_dir_q  <= skid_dir_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_stream_out.sv
// tb_piso_stream_out: directed self-checking bench for piso_stream_out (WIDTH=8, NUM_TAPS=4).
`timescale 1ns/1ps
`default_nettype none

module tb_piso_stream_out;

    logic        CLKEXT = 1'b0;
    logic        CLR_N = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] DATA_IN = '0;
    logic [2:0]  LOAD_CNT = '0;
    logic        DIR = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [7:0]  DATA_OUT;
    logic        OUT_LAST;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    piso_stream_out #(.WIDTH(8), .NUM_TAPS(4)) dut (
        .CLKEXT   (CLKEXT),
        .CLR_N    (CLR_N),
        .FLUSH    (FLUSH),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .DATA_IN  (DATA_IN),
        .LOAD_CNT (LOAD_CNT),
        .DIR      (DIR),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .DATA_OUT (DATA_OUT),
        .OUT_LAST (OUT_LAST),
        .BUSY     (BUSY)
    );

    always #5 CLKEXT = ~CLKEXT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLKEXT);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".in_ready"}, IN_READY, 0);
        chk({tag, ".out_valid"}, OUT_VALID, 0);
        chk({tag, ".out_last"}, OUT_LAST, 0);
        chk({tag, ".data_out"}, DATA_OUT, 0);
        chk({tag, ".busy"}, BUSY, 0);
    endtask

    task automatic load(input string tag, input logic [31:0] d, input logic [2:0] c, input logic dr);
        IN_VALID = 1'b1;
        DATA_IN  = d;
        LOAD_CNT = c;
        DIR      = dr;
        chk({tag, ".in_ready"}, IN_READY, 1);
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, ".valid"}, OUT_VALID, 1);
        chk({tag, ".data"}, DATA_OUT, d);
        chk({tag, ".last"}, OUT_LAST, l);
        tick();
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".valid_low"}, OUT_VALID, 0);
        chk({tag, ".busy_low"}, BUSY, 0);
    endtask

    logic [6:0]  bp_pat;
    logic [7:0]  bp_exp [4];
    logic [7:0]  b2b_data [10];
    logic        b2b_valid [10];
    logic        b2b_last [10];
    int          idx;
    logic        acc;

    initial begin
        // T1: reset state, then reset asserted mid-emission
        tick();
        chk_quiet("t1_reset");
        tick();
        CLR_N = 1'b1;
        tick();
        chk("t1_ready_after_release", IN_READY, 1);
        load("t1_load", 32'h44332211, 3'd4, 1'b0);
        beat("t1_b0", 8'h44, 1'b0);
        CLR_N = 1'b0;
        #1;
        chk_quiet("t1_mid_reset");
        tick();
        chk_quiet("t1_mid_reset_held");
        CLR_N = 1'b1;
        tick();
        chk("t1_ready_after_release2", IN_READY, 1);
        chk("t1_idle_after_release", OUT_VALID, 0);

        // T2: order
        load("t2a_load", 32'h44332211, 3'd4, 1'b0);
        beat("t2a_b0", 8'h44, 1'b0);
        beat("t2a_b1", 8'h33, 1'b0);
        beat("t2a_b2", 8'h22, 1'b0);
        beat("t2a_b3", 8'h11, 1'b1);
        chk_done("t2a");
        load("t2b_load", 32'h44332211, 3'd4, 1'b1);
        beat("t2b_b0", 8'h11, 1'b0);
        beat("t2b_b1", 8'h22, 1'b0);
        beat("t2b_b2", 8'h33, 1'b0);
        beat("t2b_b3", 8'h44, 1'b1);
        chk_done("t2b");

        // T3: count clamp
        load("t3a_load", 32'h44332211, 3'd2, 1'b0);
        beat("t3a_b0", 8'h22, 1'b0);
        beat("t3a_b1", 8'h11, 1'b1);
        chk_done("t3a");
        load("t3b_load", 32'h44332211, 3'd1, 1'b0);
        beat("t3b_b0", 8'h11, 1'b1);
        chk_done("t3b");
        load("t3c_load", 32'h44332211, 3'd0, 1'b0);
        beat("t3c_b0", 8'h44, 1'b0);
        beat("t3c_b1", 8'h33, 1'b0);
        beat("t3c_b2", 8'h22, 1'b0);
        beat("t3c_b3", 8'h11, 1'b1);
        chk_done("t3c");
        load("t3d_load", 32'h44332211, 3'd5, 1'b1);
        beat("t3d_b0", 8'h11, 1'b0);
        beat("t3d_b1", 8'h22, 1'b0);
        beat("t3d_b2", 8'h33, 1'b0);
        beat("t3d_b3", 8'h44, 1'b1);
        chk_done("t3d");

        // T4: backpressure, with DIR changed after load (must be ignored)
        bp_pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1
        bp_exp[0] = 8'h44; bp_exp[1] = 8'h33; bp_exp[2] = 8'h22; bp_exp[3] = 8'h11;
        load("t4_load", 32'h44332211, 3'd4, 1'b0);
        DIR = 1'b1;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            OUT_READY = bp_pat[i];
            chk("t4_valid", OUT_VALID, 1);
            chk("t4_data", DATA_OUT, bp_exp[idx]);
            chk("t4_last", OUT_LAST, (idx == 3) ? 1 : 0);
            tick();
            if (bp_pat[i]) idx++;
        end
        OUT_READY = 1'b1;
        chk("t4_transfers", idx, 4);
        chk_done("t4");

        // T5: flush after beat 33 is accepted
        load("t5_load", 32'h44332211, 3'd4, 1'b0);
        beat("t5_b0", 8'h44, 1'b0);
        beat("t5_b1", 8'h33, 1'b0);
        FLUSH = 1'b1;
        chk("t5_ready_during_flush", IN_READY, 0);
        tick();
        FLUSH = 1'b0;
        chk_done("t5_flushed");
        tick();
        chk("t5_still_idle", OUT_VALID, 0);
        load("t5_reload", 32'h44332211, 3'd2, 1'b1);
        beat("t5_r0", 8'h11, 1'b0);
        beat("t5_r1", 8'h22, 1'b1);
        chk_done("t5_reload");

        // T6: back-to-back loads
`ifdef PISO_STREAM_SKID_EN
        b2b_data  = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h00, 8'h00};
        b2b_valid = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        b2b_last  = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
`else
        b2b_data  = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h88, 8'h77, 8'h66, 8'h55, 8'h00};
        b2b_valid = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        b2b_last  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
`endif
        load("t6_load_a", 32'h44332211, 3'd4, 1'b0);
        IN_VALID = 1'b1;
        DATA_IN  = 32'h88776655;
        LOAD_CNT = 3'd4;
        DIR      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t6_valid%0d", i), OUT_VALID, b2b_valid[i]);
            chk($sformatf("t6_last%0d", i), OUT_LAST, b2b_last[i]);
            if (b2b_valid[i]) chk($sformatf("t6_data%0d", i), DATA_OUT, b2b_data[i]);
            acc = IN_VALID & IN_READY;
            tick();
            if (acc) IN_VALID = 1'b0;
        end
        chk("t6_b_accepted", IN_VALID, 0);
        chk_done("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
